alu_issue_stage: RTL and testbench

// - Execute-stage front end that drives the ALU operand/control interface (A, B, Cin, 4-bit Ctrl).
// - Decodes RV32I opcode/funct3/funct7[5] into the ALU Ctrl code and selects the A and B operands.
// - Registers each decoded op behind a valid/ready handshake with a 2-entry skid buffer.
// - Sits between the decode/register-read stage and the combinational ALU.

---
 rtl/alu_issue_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Execute-stage front end for a combinational ALU. Decodes
//               RV32I OP / OP-IMM / LUI / AUIPC into a 4-bit ALU control
//               code, selects the A/B operands and registers each op behind
//               a valid/ready handshake with a 2-entry skid buffer.
//               Optional macro ALU_ISSUE_STATS_EN adds issue_cnt/stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
   parameter int N = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [6:0]    opcode,
   input  logic [2:0]    funct3,
   input  logic          funct7b5,
   input  logic [N-1:0]  rs1_data,
   input  logic [N-1:0]  rs2_data,
   input  logic [N-1:0]  imm,
   input  logic [19:0]   uimm,
   input  logic [N-1:0]  pc,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic          alu_cin,
   output logic [3:0]    alu_ctrl,
`ifdef ALU_ISSUE_STATS_EN
   output logic [31:0]   issue_cnt,
   output logic [31:0]   stall_cnt,
`endif
   output logic          illegal
);

   localparam logic [6:0] c_OPC_OP    = 7'b0110011;
   localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
   localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t         r_state, w_next;
   logic           r_in_ready;
   logic [N-1:0]   r_main_a, r_main_b, r_skid_a, r_skid_b;
   logic [3:0]     r_main_ctrl, r_skid_ctrl;
   logic           r_main_ill, r_skid_ill;

   logic [N-1:0]   w_a, w_b;
   logic [3:0]     w_ctrl;
   logic           w_ill;
   logic           w_in_acc;
   logic           w_load_main_dec, w_load_main_skid, w_load_skid;

   // Shared funct3 map for the non-add/non-shift-right codes of OP and OP-IMM
   function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
      case (f3)
         3'b001:  f3_ctrl = 4'b0111;
         3'b010:  f3_ctrl = 4'b1001;
         3'b011:  f3_ctrl = 4'b1000;
         3'b100:  f3_ctrl = 4'b0011;
         3'b110:  f3_ctrl = 4'b0010;
         3'b111:  f3_ctrl = 4'b0100;
         default: f3_ctrl = 4'b0000;
      endcase
   endfunction

   // Instruction decode: control code, operand selection and illegal flag
   always_comb begin
      w_ctrl = 4'b0000;
      w_a    = '0;
      w_b    = '0;
      w_ill  = 1'b0;
      case (opcode)
         c_OPC_OP: begin
            w_a = rs1_data;
            w_b = rs2_data;
            case (funct3)
               3'b000:  w_ctrl = funct7b5 ? 4'b0001 : 4'b0000;
               3'b101:  w_ctrl = funct7b5 ? 4'b0110 : 4'b0101;
               default: begin
                  w_ctrl = f3_ctrl(funct3);
                  w_ill  = funct7b5;
               end
            endcase
         end
         c_OPC_OPIMM: begin
            w_a = rs1_data;
            w_b = imm;
            case (funct3)
               3'b000:  w_ctrl = 4'b0000;
               3'b001: begin
                  w_ctrl = 4'b0111;
                  w_b    = {{(N-5){1'b0}}, imm[4:0]};
                  w_ill  = funct7b5;
               end
               3'b101: begin
                  w_ctrl = funct7b5 ? 4'b0110 : 4'b0101;
                  w_b    = {{(N-5){1'b0}}, imm[4:0]};
               end
               default: w_ctrl = f3_ctrl(funct3);
            endcase
         end
         c_OPC_LUI: begin
            w_ctrl = 4'b1011;
            w_b    = {{(N-20){1'b0}}, uimm};
         end
         c_OPC_AUIPC: begin
            w_ctrl = 4'b1100;
            w_a    = pc;
            w_b    = {{(N-20){1'b0}}, uimm};
         end
         default: w_ill = 1'b1;
      endcase
      // Illegal ops still flow through the pipe, but carry a neutral payload
      if (w_ill) begin
         w_ctrl = 4'b0000;
         w_a    = '0;
         w_b    = '0;
      end
   end

   assign w_in_acc  = in_valid && r_in_ready;
   assign out_valid = (r_state != S_EMPTY);
   assign in_ready  = r_in_ready;
   assign alu_a     = r_main_a;
   assign alu_b     = r_main_b;
   assign alu_ctrl  = r_main_ctrl;
   assign illegal   = r_main_ill;
   assign alu_cin   = 1'b0;

   // Skid-buffer occupancy: next state and which register gets loaded
   always_comb begin
      w_next           = r_state;
      w_load_main_dec  = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_in_acc) begin
               w_next          = S_ONE;
               w_load_main_dec = 1'b1;
            end
         end
         S_ONE: begin
            if (w_in_acc && out_ready) begin
               w_load_main_dec = 1'b1;
            end else if (w_in_acc) begin
               w_next      = S_FULL;
               w_load_skid = 1'b1;
            end else if (out_ready) begin
               w_next = S_EMPTY;
            end
         end
         S_FULL: begin
            if (out_ready) begin
               w_next           = S_ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: w_next = S_EMPTY;
      endcase
   end

   // State register; in_ready is registered as "skid will be empty"
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_in_ready <= (w_next != S_FULL);
      end
   end

   // Main and skid payload registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_a    <= '0;
         r_main_b    <= '0;
         r_main_ctrl <= 4'b0000;
         r_main_ill  <= 1'b0;
         r_skid_a    <= '0;
         r_skid_b    <= '0;
         r_skid_ctrl <= 4'b0000;
         r_skid_ill  <= 1'b0;
      end else begin
         if (w_load_main_dec) begin
            r_main_a    <= w_a;
            r_main_b    <= w_b;
            r_main_ctrl <= w_ctrl;
            r_main_ill  <= w_ill;
         end else if (w_load_main_skid) begin
            r_main_a    <= r_skid_a;
            r_main_b    <= r_skid_b;
            r_main_ctrl <= r_skid_ctrl;
            r_main_ill  <= r_skid_ill;
         end
         if (w_load_skid) begin
            r_skid_a    <= w_a;
            r_skid_b    <= w_b;
            r_skid_ctrl <= w_ctrl;
            r_skid_ill  <= w_ill;
         end
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] r_issue_cnt, r_stall_cnt;

   // Free-running wrap-around counters of issued ops and stalled cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issue_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (out_valid && out_ready)  r_issue_cnt <= r_issue_cnt + 32'd1;
         if (out_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign issue_cnt = r_issue_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench for alu_issue_stage: decode vector table
//               plus hand-written handshake, backpressure and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          funct7b5;
   logic [N-1:0]  rs1_data, rs2_data, imm, pc;
   logic [19:0]   uimm;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  alu_a, alu_b;
   logic          alu_cin;
   logic [3:0]    alu_ctrl;
   logic          illegal;
`ifdef ALU_ISSUE_STATS_EN
   logic [31:0]   issue_cnt, stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   alu_issue_stage #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .uimm(uimm), .pc(pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
`ifdef ALU_ISSUE_STATS_EN
      .issue_cnt(issue_cnt), .stall_cnt(stall_cnt),
`endif
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        b5;
      logic [31:0] rs1, rs2, im;
      logic [19:0] ui;
      logic [31:0] p;
      logic [3:0]  e_ctrl;
      logic [31:0] e_a, e_b;
      logic        e_ill;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] im,
                               input logic [19:0] ui, input logic [31:0] p,
                               input logic [3:0] e_ctrl, input logic [31:0] e_a,
                               input logic [31:0] e_b, input logic e_ill);
      vec_t v;
      v.opc = opc; v.f3 = f3; v.b5 = b5; v.rs1 = rs1; v.rs2 = rs2; v.im = im;
      v.ui = ui; v.p = p; v.e_ctrl = e_ctrl; v.e_a = e_a; v.e_b = e_b; v.e_ill = e_ill;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      opcode = v.opc; funct3 = v.f3; funct7b5 = v.b5;
      rs1_data = v.rs1; rs2_data = v.rs2; imm = v.im; uimm = v.ui; pc = v.p;
   endtask

   // ADD with a tag in rs1, used for ordering checks
   function automatic vec_t tag_op(input logic [31:0] t);
      return mk(7'h33, 3'b000, 1'b0, t, 32'd1, 32'd0, 20'd0, 32'd0, 4'b0000, t, 32'd1, 1'b0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(tag_op(32'd0));
      // Decode table (N=32)
      vq.push_back(mk(7'h33, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 20'd0, 32'd0, 4'b0000, 32'd5, 32'd7, 1'b0));
      vq.push_back(mk(7'h33, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 20'd0, 32'd0, 4'b0001, 32'd10, 32'd3, 1'b0));
      vq.push_back(mk(7'h13, 3'b101, 1'b1, 32'h80000000, 32'd9, 32'h403, 20'd0, 32'd0, 4'b0110, 32'h80000000, 32'd3, 1'b0));
      vq.push_back(mk(7'h37, 3'b000, 1'b0, 32'h55, 32'h66, 32'd0, 20'h12345, 32'd0, 4'b1011, 32'd0, 32'h12345, 1'b0));
      vq.push_back(mk(7'h17, 3'b000, 1'b0, 32'h55, 32'h66, 32'd0, 20'h00001, 32'h100, 4'b1100, 32'h100, 32'd1, 1'b0));
      vq.push_back(mk(7'h7F, 3'b000, 1'b0, 32'd1, 32'd2, 32'd3, 20'd4, 32'd5, 4'b0000, 32'd0, 32'd0, 1'b1));
      vq.push_back(mk(7'h33, 3'b001, 1'b0, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b0111, 32'd11, 32'd12, 1'b0));
      vq.push_back(mk(7'h33, 3'b010, 1'b0, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b1001, 32'd11, 32'd12, 1'b0));
      vq.push_back(mk(7'h33, 3'b011, 1'b0, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b1000, 32'd11, 32'd12, 1'b0));
      vq.push_back(mk(7'h33, 3'b100, 1'b0, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b0011, 32'd11, 32'd12, 1'b0));
      vq.push_back(mk(7'h33, 3'b101, 1'b0, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b0101, 32'd11, 32'd12, 1'b0));
      vq.push_back(mk(7'h33, 3'b110, 1'b0, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b0010, 32'd11, 32'd12, 1'b0));
      vq.push_back(mk(7'h33, 3'b111, 1'b0, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b0100, 32'd11, 32'd12, 1'b0));
      vq.push_back(mk(7'h33, 3'b101, 1'b1, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b0110, 32'd11, 32'd12, 1'b0));
      vq.push_back(mk(7'h33, 3'b100, 1'b1, 32'd11, 32'd12, 32'd0, 20'd0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1));
      vq.push_back(mk(7'h13, 3'b000, 1'b1, 32'd20, 32'd99, 32'hFFFFFFFF, 20'd0, 32'd0, 4'b0000, 32'd20, 32'hFFFFFFFF, 1'b0));
      vq.push_back(mk(7'h13, 3'b001, 1'b0, 32'd20, 32'd99, 32'h0000003F, 20'd0, 32'd0, 4'b0111, 32'd20, 32'h1F, 1'b0));
      vq.push_back(mk(7'h13, 3'b001, 1'b1, 32'd20, 32'd99, 32'h00000401, 20'd0, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b1));
      vq.push_back(mk(7'h13, 3'b101, 1'b0, 32'd20, 32'd99, 32'h00000024, 20'd0, 32'd0, 4'b0101, 32'd20, 32'h4, 1'b0));
      vq.push_back(mk(7'h13, 3'b100, 1'b0, 32'd20, 32'd99, 32'h00000123, 20'd0, 32'd0, 4'b0011, 32'd20, 32'h123, 1'b0));
      vq.push_back(mk(7'h13, 3'b011, 1'b0, 32'd20, 32'd99, 32'h00000007, 20'd0, 32'd0, 4'b1000, 32'd20, 32'h7, 1'b0));

      // Reset state
      tick(); tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_alu_b", 64'(alu_b), 64'd0);
      chk("rst_ctrl", 64'(alu_ctrl), 64'd0);
      chk("rst_cin", 64'(alu_cin), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      rst = 1'b0;

      // Decode table, back-to-back with out_ready=1: one-cycle latency
      for (int i = 0; i < vq.size(); i++) begin
         chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
         drive(vq[i]);
         in_valid = 1'b1;
         tick();
         chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d_ctrl", i), 64'(alu_ctrl), 64'(vq[i].e_ctrl));
         chk($sformatf("v%0d_a", i), 64'(alu_a), 64'(vq[i].e_a));
         chk($sformatf("v%0d_b", i), 64'(alu_b), 64'(vq[i].e_b));
         chk($sformatf("v%0d_cin", i), 64'(alu_cin), 64'd0);
         chk($sformatf("v%0d_illegal", i), 64'(illegal), 64'(vq[i].e_ill));
      end
      in_valid = 1'b0;
      tick();
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      // Backpressure: three ops offered, two accepted
      out_ready = 1'b0;
      drive(tag_op(32'hA1)); in_valid = 1'b1;
      tick();
      chk("bp_in_ready_one", 64'(in_ready), 64'd1);
      drive(tag_op(32'hB2));
      tick();
      drive(tag_op(32'hC3));
      chk("bp_in_ready_full", 64'(in_ready), 64'd0);
      chk("bp_a_first", 64'(alu_a), 64'hA1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("bp_hold%0d_a", k), 64'(alu_a), 64'hA1);
         chk($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_second_valid", 64'(out_valid), 64'd1);
      chk("bp_second_a", 64'(alu_a), 64'hB2);
      chk("bp_in_ready_back", 64'(in_ready), 64'd1);
      tick();
      chk("bp_empty", 64'(out_valid), 64'd0);
      drive(tag_op(32'hC3)); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("bp_third_a", 64'(alu_a), 64'hC3);
      chk("bp_third_valid", 64'(out_valid), 64'd1);
      tick();
      chk("bp_third_once", 64'(out_valid), 64'd0);

      // Reset while FULL
      out_ready = 1'b0;
      drive(tag_op(32'hD4)); in_valid = 1'b1;
      tick();
      drive(tag_op(32'hE5));
      tick();
      in_valid = 1'b0;
      chk("rf_full_in_ready", 64'(in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      chk("rf_async_valid", 64'(out_valid), 64'd0);
      chk("rf_async_in_ready", 64'(in_ready), 64'd1);
      chk("rf_async_a", 64'(alu_a), 64'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      drive(tag_op(32'hF6)); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rf_first_valid", 64'(out_valid), 64'd1);
      chk("rf_first_a", 64'(alu_a), 64'hF6);
      tick();
      chk("rf_no_stale", 64'(out_valid), 64'd0);
      tick();
      chk("rf_no_stale2", 64'(out_valid), 64'd0);

`ifdef ALU_ISSUE_STATS_EN
      // 4 issues with 3 stall cycles, counted from a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("st_rst_issue", 64'(issue_cnt), 64'd0);
      chk("st_rst_stall", 64'(stall_cnt), 64'd0);
      out_ready = 1'b0;
      drive(tag_op(32'h1)); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      out_ready = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         drive(tag_op(32'(k))); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("st_issue_cnt", 64'(issue_cnt), 64'd4);
      chk("st_stall_cnt", 64'(stall_cnt), 64'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
